// File: rtl/clk_div_pkg.sv
// Shared mode encoding, minimum ratio and phase-length helpers for the
// multi-channel clock divider.
package clk_div_pkg;

  typedef enum logic {
    MODE_BYPASS = 1'b0,
    MODE_DIVIDE = 1'b1
  } mode_e;

  localparam int unsigned MIN_RATIO = 2;

  // Low phase takes the odd cycle so an odd ratio gives a ceil/floor split.
  function automatic logic [31:0] low_len(input logic [31:0] n);
    return n - (n >> 1);
  endfunction

  function automatic logic [31:0] high_len(input logic [31:0] n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: double-buffered ratio, phase counter, divided-clock
// register, rising-edge tick and load acknowledge.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEFAULT_RATIO = 2
) (
  input  logic             i_ref_clk,
  input  logic             i_rst,
  input  logic             i_clk_en,
  input  logic [WIDTH-1:0] i_div_ratio,
  input  logic             i_load,
  input  logic             i_sync,
  output logic             o_div_clk,
  output logic             o_tick,
  output logic             o_load_ack
);

  localparam logic [WIDTH-1:0] RST_RATIO = WIDTH'(DEFAULT_RATIO);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  logic [WIDTH-1:0] act_q, act_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             pf_q, pf_d;
  logic             dq_q, dq_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic [WIDTH-1:0] low_last;
  logic [WIDTH-1:0] high_last;
  mode_e            mode;

  assign mode      = (i_clk_en && (act_q >= WIDTH'(MIN_RATIO))) ? MODE_DIVIDE : MODE_BYPASS;
  assign low_last  = WIDTH'(low_len(32'(act_q))) - ONE;
  assign high_last = WIDTH'(high_len(32'(act_q))) - ONE;

  always_comb begin
    // NOTE: every next-state signal gets its default first, so no path leaves
    // one unassigned and no latch is inferred.
    act_d  = act_q;
    pend_d = pend_q;
    pf_d   = pf_q;
    cnt_d  = cnt_q;
    dq_d   = dq_q;
    tick_d = 1'b0;
    ack_d  = 1'b0;

    if (i_sync) begin
      // A same-cycle load bypasses the pending register and goes live at once.
      cnt_d = '0;
      dq_d  = 1'b0;
      if (i_load) begin
        act_d  = i_div_ratio;
        pend_d = i_div_ratio;
        pf_d   = 1'b0;
        ack_d  = 1'b1;
      end else if (pf_q) begin
        act_d = pend_q;
        pf_d  = 1'b0;
        ack_d = 1'b1;
      end
    end else begin
      if (mode == MODE_BYPASS) begin
        cnt_d = '0;
        dq_d  = 1'b0;
        if (pf_q) begin
          act_d = pend_q;
          pf_d  = 1'b0;
          ack_d = 1'b1;
        end
      end else if (!dq_q) begin
        if (cnt_q == low_last) begin
          dq_d   = 1'b1;
          cnt_d  = '0;
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        // High-to-low edge closes the period: the only safe point to retune.
        if (cnt_q == high_last) begin
          dq_d  = 1'b0;
          cnt_d = '0;
          if (pf_q) begin
            act_d = pend_q;
            pf_d  = 1'b0;
            ack_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      if (i_load) begin
        pend_d = i_div_ratio;
        pf_d   = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so each one samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      act_q  <= RST_RATIO;
      pend_q <= RST_RATIO;
      pf_q   <= 1'b0;
      cnt_q  <= '0;
      dq_q   <= 1'b0;
      tick_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      act_q  <= act_d;
      pend_q <= pend_d;
      pf_q   <= pf_d;
      cnt_q  <= cnt_d;
      dq_q   <= dq_d;
      tick_q <= tick_d;
      ack_q  <= ack_d;
    end
  end

  assign o_div_clk  = i_rst ? 1'b0 : ((mode == MODE_DIVIDE) ? dq_q : i_ref_clk);
  assign o_tick     = tick_q;
  assign o_load_ack = ack_q;

endmodule

// File: rtl/multi_clk_div.sv
// NUM_CH independent integer clock dividers from one reference clock, sharing
// a global re-phase sync.
module multi_clk_div #(
  parameter int NUM_CH        = 2,
  parameter int WIDTH         = 8,
  parameter int DEFAULT_RATIO = 2
) (
  input  logic                    i_ref_clk,
  input  logic                    i_rst,
  input  logic [NUM_CH-1:0]       i_clk_en,
  input  logic [NUM_CH*WIDTH-1:0] i_div_ratio,
  input  logic [NUM_CH-1:0]       i_load,
  input  logic                    i_sync,
  output logic [NUM_CH-1:0]       o_div_clk,
  output logic [NUM_CH-1:0]       o_tick,
  output logic [NUM_CH-1:0]       o_load_ack
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clk_div_chan #(
      .WIDTH        (WIDTH),
      .DEFAULT_RATIO(DEFAULT_RATIO)
    ) u_chan (
      .i_ref_clk  (i_ref_clk),
      .i_rst      (i_rst),
      .i_clk_en   (i_clk_en[c]),
      .i_div_ratio(i_div_ratio[c*WIDTH +: WIDTH]),
      .i_load     (i_load[c]),
      .i_sync     (i_sync),
      .o_div_clk  (o_div_clk[c]),
      .o_tick     (o_tick[c]),
      .o_load_ack (o_load_ack[c])
    );
  end

endmodule

// File: tb/tb_multi_clk_div.sv
// Self-checking bench for multi_clk_div: period-position reference model,
// ratio table, directed corner sequences and randomized traffic.
module tb_multi_clk_div;

  localparam int NUM_CH        = 2;
  localparam int WIDTH         = 8;
  localparam int DEFAULT_RATIO = 2;

  logic                    i_ref_clk = 1'b0;
  logic                    i_rst;
  logic [NUM_CH-1:0]       i_clk_en;
  logic [NUM_CH*WIDTH-1:0] i_div_ratio;
  logic [NUM_CH-1:0]       i_load;
  logic                    i_sync;
  logic [NUM_CH-1:0]       o_div_clk;
  logic [NUM_CH-1:0]       o_tick;
  logic [NUM_CH-1:0]       o_load_ack;

  multi_clk_div #(
    .NUM_CH       (NUM_CH),
    .WIDTH        (WIDTH),
    .DEFAULT_RATIO(DEFAULT_RATIO)
  ) dut (
    .i_ref_clk  (i_ref_clk),
    .i_rst      (i_rst),
    .i_clk_en   (i_clk_en),
    .i_div_ratio(i_div_ratio),
    .i_load     (i_load),
    .i_sync     (i_sync),
    .o_div_clk  (o_div_clk),
    .o_tick     (o_tick),
    .o_load_ack (o_load_ack)
  );

  always #5 i_ref_clk = ~i_ref_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the current period (0..A-1); the output
  // is high for the last floor(A/2) positions of each period.
  int m_act  [NUM_CH];
  int m_pend [NUM_CH];
  int m_pos  [NUM_CH];
  bit m_pf   [NUM_CH];
  bit m_tick [NUM_CH];
  bit m_ack  [NUM_CH];

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_act[c]  = DEFAULT_RATIO;
      m_pend[c] = DEFAULT_RATIO;
      m_pos[c]  = 0;
      m_pf[c]   = 1'b0;
      m_tick[c] = 1'b0;
      m_ack[c]  = 1'b0;
    end
  endtask

  function automatic bit divides(int c);
    return i_clk_en[c] && (m_act[c] >= 2);
  endfunction

  task automatic apply_pending(int c);
    m_act[c] = m_pend[c];
    m_pf[c]  = 1'b0;
    m_ack[c] = 1'b1;
  endtask

  task automatic model_step();
    if (i_rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      int r;
      bit div;
      r         = int'(i_div_ratio[c*WIDTH +: WIDTH]);
      div       = divides(c);
      m_tick[c] = 1'b0;
      m_ack[c]  = 1'b0;
      if (i_sync) begin
        m_pos[c] = 0;
        if (i_load[c]) begin
          m_pend[c] = r;
          m_act[c]  = r;
          m_pf[c]   = 1'b0;
          m_ack[c]  = 1'b1;
        end else if (m_pf[c]) begin
          apply_pending(c);
        end
      end else begin
        if (div) begin
          m_pos[c]++;
          if (m_pos[c] == m_act[c] - m_act[c] / 2) m_tick[c] = 1'b1;
          if (m_pos[c] == m_act[c]) begin
            m_pos[c] = 0;
            if (m_pf[c]) apply_pending(c);
          end
        end else begin
          m_pos[c] = 0;
          if (m_pf[c]) apply_pending(c);
        end
        if (i_load[c]) begin
          m_pend[c] = r;
          m_pf[c]   = 1'b1;
        end
      end
    end
  endtask

  function automatic logic exp_clk(int c);
    if (i_rst) return 1'b0;
    if (divides(c)) return (m_pos[c] >= m_act[c] - m_act[c] / 2);
    return i_ref_clk;
  endfunction

  task automatic compare_outputs(input bit full);
    for (int c = 0; c < NUM_CH; c++) begin
      if (full) begin
        check($sformatf("tick[%0d]", c), o_tick[c], m_tick[c]);
        check($sformatf("load_ack[%0d]", c), o_load_ack[c], m_ack[c]);
      end
      check($sformatf("div_clk[%0d] clk=%0b", c, i_ref_clk), o_div_clk[c], exp_clk(c));
    end
  endtask

  // One reference cycle: drive, clock, update model, check both clock phases.
  task automatic cycle(input bit rst, input logic [NUM_CH-1:0] en,
                       input logic [NUM_CH*WIDTH-1:0] ratio,
                       input logic [NUM_CH-1:0] load, input bit sync);
    i_rst       = rst;
    i_clk_en    = en;
    i_div_ratio = ratio;
    i_load      = load;
    i_sync      = sync;
    @(posedge i_ref_clk);
    model_step();
    #1;
    compare_outputs(1'b1);
    @(negedge i_ref_clk);
    #1;
    compare_outputs(1'b0);
  endtask

  logic [NUM_CH-1:0]       en_r;
  logic [NUM_CH*WIDTH-1:0] ratio_r;

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, en_r, ratio_r, '0, 1'b0);
  endtask

  task automatic load(input logic [NUM_CH-1:0] mask, input bit sync);
    cycle(1'b0, en_r, ratio_r, mask, sync);
  endtask

  task automatic set_ratio(input int c, input int val);
    ratio_r[c*WIDTH +: WIDTH] = WIDTH'(val);
  endtask

  // Cycles until channel c's output reaches lvl (bounded).
  task automatic run_until(input int c, input logic lvl, output int n);
    n = 0;
    do begin
      idle(1);
      n++;
    end while (o_div_clk[c] !== lvl && n < 1000);
  endtask

  typedef struct {
    int ratio;
    int exp_low;
    int exp_high;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n, n2, acks, ticks0, ticks1;
    int last[NUM_CH];

    vecs[0] = '{2, 1, 1};
    vecs[1] = '{3, 2, 1};
    vecs[2] = '{4, 2, 2};
    vecs[3] = '{5, 3, 2};
    vecs[4] = '{6, 3, 3};
    vecs[5] = '{9, 5, 4};
    vecs[6] = '{255, 128, 127};

    model_reset();
    en_r    = '0;
    ratio_r = '0;
    repeat (3) cycle(1'b1, en_r, ratio_r, '0, 1'b0);
    check("reset div_clk", o_div_clk, 0);
    check("reset tick", o_tick, 0);
    check("reset ack", o_load_ack, 0);

    // A0=4, A1=5 loaded in bypass, then both enabled.
    set_ratio(0, 4);
    set_ratio(1, 5);
    load(2'b11, 1'b0);
    check("bypass ack not early", o_load_ack, 0);
    idle(1);
    check("bypass ack next cycle", o_load_ack, 2'b11);
    en_r   = 2'b11;
    last   = '{-1, -1};
    ticks0 = 0;
    ticks1 = 0;
    for (int k = 0; k < 40; k++) begin
      idle(1);
      for (int c = 0; c < NUM_CH; c++) begin
        if (o_tick[c]) begin
          if (last[c] >= 0) check($sformatf("tick spacing[%0d]", c), k - last[c], (c == 0) ? 4 : 5);
          last[c] = k;
          if (c == 0) ticks0++; else ticks1++;
        end
      end
    end
    check("tick count ch0", ticks0, 10);
    check("tick count ch1", ticks1, 8);

    // Ratio table on ch0: sync-load, then measure low/high/low lengths.
    en_r = 2'b01;
    for (int i = 0; i < 7; i++) begin
      set_ratio(0, vecs[i].ratio);
      load(2'b01, 1'b1);
      check($sformatf("sync-load ack r=%0d", vecs[i].ratio), o_load_ack[0], 1);
      run_until(0, 1'b1, n);
      check($sformatf("low len r=%0d", vecs[i].ratio), n, vecs[i].exp_low);
      check($sformatf("tick at rise r=%0d", vecs[i].ratio), o_tick[0], 1);
      run_until(0, 1'b0, n);
      check($sformatf("high len r=%0d", vecs[i].ratio), n, vecs[i].exp_high);
      run_until(0, 1'b1, n);
      check($sformatf("low len2 r=%0d", vecs[i].ratio), n, vecs[i].exp_low);
    end

    // Two loads before the boundary: one ack, last value wins.
    set_ratio(0, 6);
    load(2'b01, 1'b1);
    set_ratio(0, 7);
    load(2'b01, 1'b0);
    set_ratio(0, 9);
    load(2'b01, 1'b0);
    acks = 0;
    n    = 0;
    while (acks == 0 && n < 20) begin
      idle(1);
      n++;
      if (o_load_ack[0]) acks++;
    end
    check("double load ack latency", n, 4);
    run_until(0, 1'b1, n);
    if (o_load_ack[0]) acks++;
    run_until(0, 1'b0, n2);
    if (o_load_ack[0]) acks++;
    check("double load single ack", acks, 1);
    check("ratio 9 low", n, 5);
    check("ratio 9 high", n2, 4);

    // Load 3 mid-high while running at 6: old period completes.
    set_ratio(0, 6);
    load(2'b01, 1'b1);
    run_until(0, 1'b1, n);
    idle(1);
    set_ratio(0, 3);
    load(2'b01, 1'b0);
    check("still high after load", o_div_clk[0], 1);
    run_until(0, 1'b0, n);
    check("old high completes", n, 1);
    check("ack at boundary", o_load_ack[0], 1);
    run_until(0, 1'b1, n);
    check("ratio 3 low", n, 2);
    run_until(0, 1'b0, n);
    check("ratio 3 high", n, 1);

    // Bypass: ratio 1, ratio 0, enable low.
    ticks0 = 0;
    set_ratio(0, 1);
    load(2'b01, 1'b1);
    for (int k = 0; k < 6; k++) begin idle(1); ticks0 += o_tick[0]; end
    set_ratio(0, 0);
    load(2'b01, 1'b1);
    for (int k = 0; k < 6; k++) begin idle(1); ticks0 += o_tick[0]; end
    check("no ticks in bypass", ticks0, 0);
    en_r = 2'b00;
    set_ratio(0, 4);
    load(2'b01, 1'b0);
    check("bypass load ack not early", o_load_ack[0], 0);
    idle(1);
    check("bypass load ack", o_load_ack[0], 1);
    en_r = 2'b01;
    run_until(0, 1'b1, n);
    check("divide after enable", n, 2);

    // Sync at arbitrary phase with ch0=4, ch1=6.
    en_r = 2'b11;
    set_ratio(0, 4);
    set_ratio(1, 6);
    load(2'b11, 1'b1);
    idle($urandom_range(3, 20));
    load(2'b00, 1'b1);
    check("sync forces low", o_div_clk, 2'b00);
    last = '{-1, -1};
    for (int k = 1; k <= 8; k++) begin
      idle(1);
      for (int c = 0; c < NUM_CH; c++)
        if (last[c] < 0 && o_div_clk[c]) last[c] = k;
    end
    check("sync rise ch0", last[0], 2);
    check("sync rise ch1", last[1], 3);

    // Sync colliding with a rising and then a falling terminal count.
    n = 0;
    while (m_pos[0] != 1 && n < 20) begin idle(1); n++; end
    load(2'b00, 1'b1);
    check("sync vs rise: low", o_div_clk[0], 0);
    check("sync vs rise: no tick", o_tick[0], 0);
    n = 0;
    while (m_pos[0] != 3 && n < 20) begin idle(1); n++; end
    check("pre-fall high", o_div_clk[0], 1);
    load(2'b00, 1'b1);
    check("sync vs fall: low", o_div_clk[0], 0);
    run_until(0, 1'b1, n);
    check("sync vs fall: next rise", n, 2);

    // Asynchronous reset mid-high phase.
    en_r = 2'b01;
    check("high before reset", o_div_clk[0], 1);
    i_rst = 1'b1;
    #1;
    check("async reset div_clk", o_div_clk, 0);
    check("async reset tick", o_tick, 0);
    check("async reset ack", o_load_ack, 0);
    model_reset();
    repeat (3) cycle(1'b1, en_r, ratio_r, '0, 1'b0);
    run_until(0, 1'b1, n);
    check("default ratio low", n, 1);
    run_until(0, 1'b0, n);
    check("default ratio high", n, 1);

    // Randomized traffic against the model.
    for (int k = 0; k < 2500; k++) begin
      logic [NUM_CH-1:0]       en, ld;
      logic [NUM_CH*WIDTH-1:0] ratio;
      int                      r;
      for (int c = 0; c < NUM_CH; c++) begin
        en[c] = ($urandom_range(0, 9) != 0);
        ld[c] = ($urandom_range(0, 7) == 0);
        r     = $urandom_range(0, 12);
        if ($urandom_range(0, 49) == 0) r = $urandom_range(13, 255);
        ratio[c*WIDTH +: WIDTH] = WIDTH'(r);
      end
      cycle(($urandom_range(0, 299) == 0), en, ratio, ld, ($urandom_range(0, 29) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
